spi_axil_regs: RTL and testbench
================================

# spi_axil_regs

AXI4-Lite slave register file that sits directly upstream of the SPI master core (`SPI_regs`/`SPI_top`). It turns bus writes into the core's configuration, transmit word and single-cycle `start_i` pulse. It also samples the core's `busy_o`/`miso_data_o` into readable status and receive registers. One outstanding read and one outstanding write are supported; the read and write channels are independent.

## Interface
- `ADDR_W`, 5: AXI address width; only bits [4:2] are decoded.
- `GCLK` in 1: the single clock.
- `RST` in 1: synchronous, active-high reset.
- `s_axi_awaddr_i` in ADDR_W / `s_axi_awvalid_i` in 1 / `s_axi_awready_o` out 1: write address channel.
- `s_axi_wdata_i` in 32 / `s_axi_wstrb_i` in 4 / `s_axi_wvalid_i` in 1 / `s_axi_wready_o` out 1: write data channel.
- `s_axi_bresp_o` out 2 / `s_axi_bvalid_o` out 1 / `s_axi_bready_i` in 1: write response channel.
- `s_axi_araddr_i` in ADDR_W / `s_axi_arvalid_i` in 1 / `s_axi_arready_o` out 1: read address channel.
- `s_axi_rdata_o` out 32 / `s_axi_rresp_o` out 2 / `s_axi_rvalid_o` out 1 / `s_axi_rready_i` in 1: read data channel.
- `start_o` out 1: transfer start pulse to the core.
- `busy_i` in 1: core busy.
- `spi_mode_o`, `sck_speed_o`, `word_len_o` out 2 each: core configuration.
- `IFG_o`, `CS_SCK_o`, `SCK_CS_o` out 8 each: core timing.
- `mosi_data_o` out 32: transmit word.
- `miso_data_i` in 32: receive word from the core.

## Operation
- Register map:
  - 0x00 CTRL: W, bit0 START (self-clearing).
  - 0x04 STATUS: bit0 BUSY (RO, equals `busy_i | start_pend`); bit1 DONE (sticky, write-1-to-clear).
  - 0x08 CONFIG: [1:0] mode, [3:2] speed, [5:4] word_len.
  - 0x0C TIMING: [7:0] IFG, [15:8] CS_SCK, [23:16] SCK_CS.
  - 0x10 TXDATA.
  - 0x14 RXDATA (RO).
  - 0x18 and 0x1C are unmapped.
- Write strobes: WSTRB byte lanes are honoured on every register. CTRL.START and the DONE clear need `wstrb[0]`.
- Start: a CTRL write with START=1 while BUSY=0 pulses `start_o` for exactly one cycle and sets `start_pend`.
  - `start_pend` clears on the first cycle `busy_i` is sampled 1.
  - A START write while BUSY=1 returns SLVERR and produces no pulse.
- Writes while BUSY=1: writes to CONFIG, TIMING or TXDATA are dropped and return SLVERR.
- Transfer completion: `busy_i` is registered. On a registered 1→0 edge, RXDATA captures `miso_data_i` and DONE sets. If a W1C of DONE lands in the same cycle, the set wins.
- Response codes:
  - Unmapped address: reads return 0 with SLVERR; writes have no effect and return SLVERR.
  - A write to STATUS bit0 or to RXDATA is ignored and returns OKAY.
  - Every other access returns OKAY (2'b00). SLVERR is 2'b10.
- Reset values: every register and every output is 0, including all READY/VALID signals. BUSY reads `busy_i`.

## Timing
- Write path:
  - AWREADY and WREADY are 1 while their channel has nothing captured. Each drops for the cycle after its handshake.
  - AW and W may arrive in either order or in the same cycle.
  - The register update and `start_o` occur in the cycle after both are captured. BVALID rises in that same cycle and holds until BREADY.
  - AWREADY and WREADY return to 1 the cycle after the B handshake.
- Read path:
  - ARREADY is 1 when no read is in flight.
  - RVALID/RDATA are registered the cycle after the AR handshake. RDATA is held stable until RREADY.
  - A read and a write committing in the same cycle: the read returns the pre-write value.
- `start_o` to `busy_i` latency from the core: `start_pend` keeps BUSY=1 across the gap, so there is no false idle window.
- `RST` asserted mid-transaction: the transaction is aborted and no B or R response is issued. All state returns to reset values on the next edge.

## Configuration
- `SPI_AXIL_IRQ_EN`: when defined, adds `irq_o` (out 1) and CTRL bit1 IRQ_EN (reset 0).
  - `irq_o` is registered and equals `DONE & IRQ_EN`. It is level-sensitive and clears one cycle after the W1C.
  - When undefined, there is no `irq_o` port, CTRL bit1 is ignored and reads as 0.

## Structure
- `spi_axil_pkg` holds:
  - register offsets;
  - bit/field positions;
  - RESP_OKAY / RESP_SLVERR;
  - reset constants.
- One sub-module: `axil_slave_if`. It handles AW/W/B/AR/R handshakes and exposes `wr_en`, `wr_addr`, `wr_data`, `wr_strb`, `wr_resp` and `rd_en`, `rd_addr`, `rd_data`, `rd_resp` to the register logic.

## Test plan
- Write CONFIG=0x0000_0025 then read it back → `spi_mode_o`=1, `sck_speed_o`=1, `word_len_o`=2; readback 0x25; BRESP and RRESP are OKAY.
- W arrives 3 cycles before AW: write TXDATA=0xA5A5_1234 → one B response; `mosi_data_o`=0xA5A5_1234.
- Write CTRL=1 → `start_o` high for exactly 1 cycle. STATUS reads 0x1 before `busy_i` rises.
- Hold `busy_i`=1 for 10 cycles with `miso_data_i`=0xDEAD_BEEF, then drop it → RXDATA=0xDEAD_BEEF, STATUS=0x2. Write STATUS=0x2 → STATUS=0x0.
- With `busy_i`=1, write CTRL=1 and TXDATA=0x1 → both return SLVERR; no `start_o`; TXDATA unchanged.
- Read 0x18 → RDATA=0, RRESP=SLVERR. Assert RST while BVALID is pending → BVALID=0 and all registers return to 0.

Source files
------------

// File: rtl/spi_axil_pkg.sv
// Shared constants for the SPI AXI4-Lite register file: word indices, field
// positions, response codes and reset values.
package spi_axil_pkg;

    // Word index (address bits [4:2]) of each register
    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_STATUS = 3'd1;
    localparam logic [2:0] REG_CONFIG = 3'd2;
    localparam logic [2:0] REG_TIMING = 3'd3;
    localparam logic [2:0] REG_TXDATA = 3'd4;
    localparam logic [2:0] REG_RXDATA = 3'd5;

    localparam int CTRL_START_BIT  = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;
    localparam int STATUS_BUSY_BIT = 0;
    localparam int STATUS_DONE_BIT = 1;

    localparam int CFG_MODE_LSB    = 0;
    localparam int CFG_SPEED_LSB   = 2;
    localparam int CFG_WLEN_LSB    = 4;
    localparam int TIM_IFG_LSB     = 0;
    localparam int TIM_CS_SCK_LSB  = 8;
    localparam int TIM_SCK_CS_LSB  = 16;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [5:0]  CONFIG_RST = 6'd0;
    localparam logic [23:0] TIMING_RST = 24'd0;
    localparam logic [31:0] TXDATA_RST = 32'd0;
    localparam logic [31:0] RXDATA_RST = 32'd0;

    // Merge new_v into old_v on the byte lanes selected by strb
    function automatic logic [31:0] apply_strb(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_v;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[b*8 +: 8] = new_v[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/axil_slave_if.sv
// AXI4-Lite slave handshake engine: one outstanding write and one outstanding
// read, presented to register logic as single-cycle wr_en / rd_en strobes.
module axil_slave_if #(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] s_axi_awaddr_i,
    input  logic              s_axi_awvalid_i,
    output logic              s_axi_awready_o,
    input  logic [31:0]       s_axi_wdata_i,
    input  logic [3:0]        s_axi_wstrb_i,
    input  logic              s_axi_wvalid_i,
    output logic              s_axi_wready_o,
    output logic [1:0]        s_axi_bresp_o,
    output logic              s_axi_bvalid_o,
    input  logic              s_axi_bready_i,
    input  logic [ADDR_W-1:0] s_axi_araddr_i,
    input  logic              s_axi_arvalid_i,
    output logic              s_axi_arready_o,
    output logic [31:0]       s_axi_rdata_o,
    output logic [1:0]        s_axi_rresp_o,
    output logic              s_axi_rvalid_o,
    input  logic              s_axi_rready_i,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic [3:0]        wr_strb,
    input  logic [1:0]        wr_resp,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [31:0]       rd_data,
    input  logic [1:0]        rd_resp
);

    // Valid/ready: a beat transfers on a rising clk edge where both are 1;
    // a valid, once raised, holds with its payload stable until that edge.
    logic aw_full, w_full, aw_full_n, w_full_n, rvalid_n;
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

    assign aw_hs = s_axi_awvalid_i & s_axi_awready_o;
    assign w_hs  = s_axi_wvalid_i  & s_axi_wready_o;
    assign b_hs  = s_axi_bvalid_o  & s_axi_bready_i;
    assign ar_hs = s_axi_arvalid_i & s_axi_arready_o;
    assign r_hs  = s_axi_rvalid_o  & s_axi_rready_i;

    // Captured AW/W stay held until the B handshake frees both slots together
    assign aw_full_n = b_hs ? 1'b0 : (aw_full | aw_hs);
    assign w_full_n  = b_hs ? 1'b0 : (w_full  | w_hs);
    assign rvalid_n  = ar_hs ? 1'b1 : (r_hs ? 1'b0 : s_axi_rvalid_o);

    assign wr_en   = aw_full & w_full & ~s_axi_bvalid_o;
    assign rd_en   = ar_hs;
    assign rd_addr = s_axi_araddr_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            aw_full         <= 1'b0;
            w_full          <= 1'b0;
            wr_addr         <= '0;
            wr_data         <= '0;
            wr_strb         <= '0;
            s_axi_awready_o <= 1'b0;
            s_axi_wready_o  <= 1'b0;
            s_axi_bvalid_o  <= 1'b0;
            s_axi_bresp_o   <= 2'b00;
            s_axi_arready_o <= 1'b0;
            s_axi_rvalid_o  <= 1'b0;
            s_axi_rdata_o   <= '0;
            s_axi_rresp_o   <= 2'b00;
        end else begin
            aw_full         <= aw_full_n;
            w_full          <= w_full_n;
            s_axi_awready_o <= ~aw_full_n;
            s_axi_wready_o  <= ~w_full_n;
            if (aw_hs) wr_addr <= s_axi_awaddr_i;
            if (w_hs) begin
                wr_data <= s_axi_wdata_i;
                wr_strb <= s_axi_wstrb_i;
            end
            if (wr_en) begin
                s_axi_bvalid_o <= 1'b1;
                s_axi_bresp_o  <= wr_resp;
            end else if (b_hs) begin
                s_axi_bvalid_o <= 1'b0;
            end
            s_axi_rvalid_o  <= rvalid_n;
            s_axi_arready_o <= ~rvalid_n;
            if (ar_hs) begin
                s_axi_rdata_o <= rd_data;
                s_axi_rresp_o <= rd_resp;
            end
        end
    end

endmodule

// File: rtl/spi_axil_regs.sv
// AXI4-Lite register file in front of the SPI master core.
// Optional SPI_AXIL_IRQ_EN adds irq_o and CTRL.IRQ_EN.
module spi_axil_regs
    import spi_axil_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic              GCLK,
    input  logic              RST,
    input  logic [ADDR_W-1:0] s_axi_awaddr_i,
    input  logic              s_axi_awvalid_i,
    output logic              s_axi_awready_o,
    input  logic [31:0]       s_axi_wdata_i,
    input  logic [3:0]        s_axi_wstrb_i,
    input  logic              s_axi_wvalid_i,
    output logic              s_axi_wready_o,
    output logic [1:0]        s_axi_bresp_o,
    output logic              s_axi_bvalid_o,
    input  logic              s_axi_bready_i,
    input  logic [ADDR_W-1:0] s_axi_araddr_i,
    input  logic              s_axi_arvalid_i,
    output logic              s_axi_arready_o,
    output logic [31:0]       s_axi_rdata_o,
    output logic [1:0]        s_axi_rresp_o,
    output logic              s_axi_rvalid_o,
    input  logic              s_axi_rready_i,
    output logic              start_o,
    input  logic              busy_i,
    output logic [1:0]        spi_mode_o,
    output logic [1:0]        sck_speed_o,
    output logic [1:0]        word_len_o,
    output logic [7:0]        IFG_o,
    output logic [7:0]        CS_SCK_o,
    output logic [7:0]        SCK_CS_o,
    output logic [31:0]       mosi_data_o,
`ifdef SPI_AXIL_IRQ_EN
    output logic              irq_o,
`endif
    input  logic [31:0]       miso_data_i
);

    logic              wr_en, rd_en;
    logic [ADDR_W-1:0] wr_addr, rd_addr;
    logic [31:0]       wr_data, rd_data;
    logic [3:0]        wr_strb;
    logic [1:0]        wr_resp, rd_resp;

    axil_slave_if #(.ADDR_W(ADDR_W)) u_if (
        .clk(GCLK), .rst(RST),
        .s_axi_awaddr_i(s_axi_awaddr_i), .s_axi_awvalid_i(s_axi_awvalid_i),
        .s_axi_awready_o(s_axi_awready_o),
        .s_axi_wdata_i(s_axi_wdata_i), .s_axi_wstrb_i(s_axi_wstrb_i),
        .s_axi_wvalid_i(s_axi_wvalid_i), .s_axi_wready_o(s_axi_wready_o),
        .s_axi_bresp_o(s_axi_bresp_o), .s_axi_bvalid_o(s_axi_bvalid_o),
        .s_axi_bready_i(s_axi_bready_i),
        .s_axi_araddr_i(s_axi_araddr_i), .s_axi_arvalid_i(s_axi_arvalid_i),
        .s_axi_arready_o(s_axi_arready_o),
        .s_axi_rdata_o(s_axi_rdata_o), .s_axi_rresp_o(s_axi_rresp_o),
        .s_axi_rvalid_o(s_axi_rvalid_o), .s_axi_rready_i(s_axi_rready_i),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
        .wr_resp(wr_resp),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_resp(rd_resp)
    );

    logic [5:0]  cfg_q;
    logic [23:0] tim_q;
    logic [31:0] tx_q, rx_q, cfg_new, tim_new, tx_new;
    logic        done_q, start_pend_q, busy_q, irq_en_q;
    logic        busy, busy_fall, start_req, start_hit, done_clr;
    logic        cfg_we, tim_we, tx_we;
    logic [2:0]  wr_idx, rd_idx;

    // start_pend bridges the gap between start_o and the core raising busy_i
    assign busy      = busy_i | start_pend_q;
    assign busy_fall = busy_q & ~busy_i;
    assign wr_idx    = wr_addr[4:2];
    assign rd_idx    = rd_addr[4:2];
    assign start_req = wr_strb[0] & wr_data[CTRL_START_BIT];
    assign cfg_new   = apply_strb({26'd0, cfg_q}, wr_data, wr_strb);
    assign tim_new   = apply_strb({8'd0, tim_q}, wr_data, wr_strb);
    assign tx_new    = apply_strb(tx_q, wr_data, wr_strb);

    always_comb begin
        wr_resp   = RESP_OKAY;
        start_hit = 1'b0;
        done_clr  = 1'b0;
        cfg_we    = 1'b0;
        tim_we    = 1'b0;
        tx_we     = 1'b0;
        case (wr_idx)
            REG_CTRL: begin
                if (start_req && busy) wr_resp = RESP_SLVERR;
                else start_hit = wr_en & start_req;
            end
            REG_STATUS: done_clr = wr_en & wr_strb[0] & wr_data[STATUS_DONE_BIT];
            REG_CONFIG: if (busy) wr_resp = RESP_SLVERR; else cfg_we = wr_en;
            REG_TIMING: if (busy) wr_resp = RESP_SLVERR; else tim_we = wr_en;
            REG_TXDATA: if (busy) wr_resp = RESP_SLVERR; else tx_we = wr_en;
            REG_RXDATA: wr_resp = RESP_OKAY;
            default:    wr_resp = RESP_SLVERR;
        endcase
    end

    always_comb begin
        rd_data = '0;
        rd_resp = RESP_OKAY;
        case (rd_idx)
            REG_CTRL: begin
`ifdef SPI_AXIL_IRQ_EN
                rd_data[CTRL_IRQ_EN_BIT] = irq_en_q;
`endif
            end
            REG_STATUS: begin
                rd_data[STATUS_BUSY_BIT] = busy;
                rd_data[STATUS_DONE_BIT] = done_q;
            end
            REG_CONFIG: rd_data[5:0]  = cfg_q;
            REG_TIMING: rd_data[23:0] = tim_q;
            REG_TXDATA: rd_data       = tx_q;
            REG_RXDATA: rd_data       = rx_q;
            default:    rd_resp       = RESP_SLVERR;
        endcase
    end

    always_ff @(posedge GCLK) begin
        if (RST) begin
            cfg_q        <= CONFIG_RST;
            tim_q        <= TIMING_RST;
            tx_q         <= TXDATA_RST;
            rx_q         <= RXDATA_RST;
            done_q       <= 1'b0;
            start_pend_q <= 1'b0;
            busy_q       <= 1'b0;
            start_o      <= 1'b0;
            irq_en_q     <= 1'b0;
        end else begin
            busy_q  <= busy_i;
            start_o <= start_hit;
            if (start_hit) start_pend_q <= 1'b1;
            else if (busy_i) start_pend_q <= 1'b0;
            if (cfg_we) cfg_q <= cfg_new[5:0];
            if (tim_we) tim_q <= tim_new[23:0];
            if (tx_we)  tx_q  <= tx_new;
            // Completion beats a same-cycle W1C so a finished transfer is never lost
            if (busy_fall) begin
                rx_q   <= miso_data_i;
                done_q <= 1'b1;
            end else if (done_clr) begin
                done_q <= 1'b0;
            end
`ifdef SPI_AXIL_IRQ_EN
            if (wr_en && wr_idx == REG_CTRL && wr_strb[0] && wr_resp == RESP_OKAY)
                irq_en_q <= wr_data[CTRL_IRQ_EN_BIT];
`endif
        end
    end

`ifdef SPI_AXIL_IRQ_EN
    always_ff @(posedge GCLK) begin
        if (RST) irq_o <= 1'b0;
        else     irq_o <= done_q & irq_en_q;
    end
`endif

    assign spi_mode_o  = cfg_q[CFG_MODE_LSB +: 2];
    assign sck_speed_o = cfg_q[CFG_SPEED_LSB +: 2];
    assign word_len_o  = cfg_q[CFG_WLEN_LSB +: 2];
    assign IFG_o       = tim_q[TIM_IFG_LSB +: 8];
    assign CS_SCK_o    = tim_q[TIM_CS_SCK_LSB +: 8];
    assign SCK_CS_o    = tim_q[TIM_SCK_CS_LSB +: 8];
    assign mosi_data_o = tx_q;

    logic unused_ok;
    assign unused_ok = ^{rd_en, wr_addr, rd_addr, cfg_new[31:6], tim_new[31:24], irq_en_q};

endmodule

// File: tb/tb_spi_axil_regs.sv
// Self-checking bench for spi_axil_regs: reset, table vectors, directed
// start/busy/completion sequences, randomized traffic against a model.
module tb_spi_axil_regs;

    localparam logic [1:0] OK  = 2'b00;
    localparam logic [1:0] ERR = 2'b10;

    logic        GCLK = 1'b0;
    logic        RST;
    logic [4:0]  awaddr, araddr;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        start_o, busy_i;
    logic [1:0]  spi_mode, sck_speed, word_len;
    logic [7:0]  ifg, cs_sck, sck_cs;
    logic [31:0] mosi, miso;
`ifdef SPI_AXIL_IRQ_EN
    logic        irq;
`endif

    always #5 GCLK = ~GCLK;

    spi_axil_regs #(.ADDR_W(5)) dut (
        .GCLK(GCLK), .RST(RST),
        .s_axi_awaddr_i(awaddr), .s_axi_awvalid_i(awvalid), .s_axi_awready_o(awready),
        .s_axi_wdata_i(wdata), .s_axi_wstrb_i(wstrb), .s_axi_wvalid_i(wvalid),
        .s_axi_wready_o(wready),
        .s_axi_bresp_o(bresp), .s_axi_bvalid_o(bvalid), .s_axi_bready_i(bready),
        .s_axi_araddr_i(araddr), .s_axi_arvalid_i(arvalid), .s_axi_arready_o(arready),
        .s_axi_rdata_o(rdata), .s_axi_rresp_o(rresp), .s_axi_rvalid_o(rvalid),
        .s_axi_rready_i(rready),
        .start_o(start_o), .busy_i(busy_i),
        .spi_mode_o(spi_mode), .sck_speed_o(sck_speed), .word_len_o(word_len),
        .IFG_o(ifg), .CS_SCK_o(cs_sck), .SCK_CS_o(sck_cs),
        .mosi_data_o(mosi),
`ifdef SPI_AXIL_IRQ_EN
        .irq_o(irq),
`endif
        .miso_data_i(miso)
    );

    int n_vec = 0;
    int n_miss = 0;
    int start_cnt = 0;

    always @(negedge GCLK) if (start_o === 1'b1) start_cnt++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_reg[8];
    logic [31:0] m_mask[8];
    logic [31:0] m_rx;
    bit          m_done;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_reg[i] = 32'd0;
        m_rx = 32'd0;
        m_done = 0;
    endtask

    task automatic model_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                               input bit busy, output logic [1:0] resp);
        int idx;
        idx = int'(a) / 4;
        resp = OK;
        case (idx)
            0: if (s[0] && d[0] && busy) resp = ERR;
            1: if (s[0] && d[1]) m_done = 0;
            2, 3, 4: begin
                if (busy) resp = ERR;
                else begin
                    for (int b = 0; b < 4; b++)
                        if (s[b]) m_reg[idx][b*8 +: 8] = d[b*8 +: 8];
                    m_reg[idx] = m_reg[idx] & m_mask[idx];
                end
            end
            5: resp = OK;
            default: resp = ERR;
        endcase
    endtask

    task automatic model_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] resp);
        int idx;
        idx = int'(a) / 4;
        d = 32'd0;
        resp = OK;
        case (idx)
            1: d = {30'd0, m_done, busy_i};
            2, 3, 4: d = m_reg[idx];
            5: d = m_rx;
            6, 7: resp = ERR;
            default: d = 32'd0;
        endcase
    endtask

    // ---------------- bus drivers ----------------
    task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_dly, input int w_dly, output logic [1:0] resp);
        bit aw_done = 0;
        bit w_done = 0;
        bit got = 0;
        int cyc = 0;
        resp = 2'bxx;
        while (!(aw_done && w_done) && cyc < 100) begin
            @(negedge GCLK);
            awaddr = a; wdata = d; wstrb = s;
            awvalid = !aw_done && cyc >= aw_dly;
            wvalid  = !w_done && cyc >= w_dly;
            if (awvalid && awready) aw_done = 1;
            if (wvalid && wready) w_done = 1;
            cyc++;
        end
        @(negedge GCLK);
        awvalid = 0; wvalid = 0; bready = 1;
        if (!(aw_done && w_done)) check("aw_w_accept_timeout", 32'd0, 32'd1);
        for (int i = 0; i < 50 && !got; i++) begin
            if (bvalid) begin
                resp = bresp;
                got = 1;
            end
            @(negedge GCLK);
        end
        bready = 0;
        if (!got) check("bvalid_timeout", 32'd0, 32'd1);
    endtask

    task automatic axi_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] resp);
        bit acc = 0;
        bit got = 0;
        d = 32'hxxxx_xxxx;
        resp = 2'bxx;
        for (int i = 0; i < 100 && !acc; i++) begin
            @(negedge GCLK);
            araddr = a; arvalid = 1;
            if (arready) acc = 1;
        end
        @(negedge GCLK);
        arvalid = 0; rready = 1;
        if (!acc) check("ar_accept_timeout", 32'd0, 32'd1);
        for (int i = 0; i < 50 && !got; i++) begin
            if (rvalid) begin
                d = rdata;
                resp = rresp;
                got = 1;
            end
            @(negedge GCLK);
        end
        rready = 0;
        if (!got) check("rvalid_timeout", 32'd0, 32'd1);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                      input int awd, input int wd, input bit busy,
                      output logic [1:0] got, output logic [1:0] exp);
        model_write(a, d, s, busy, exp);
        axi_write(a, d, s, awd, wd, got);
    endtask

    task automatic rd_check(input string name, input logic [4:0] a);
        logic [31:0] d, ed;
        logic [1:0]  r, er;
        model_read(a, ed, er);
        axi_read(a, d, r);
        check({name, "_rdata"}, d, ed);
        check({name, "_rresp"}, {30'd0, r}, {30'd0, er});
    endtask

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  bresp;
        logic [31:0] rdata;
        logic [1:0]  rresp;
    } vec_t;

    vec_t tbl[13];

    initial begin
        logic [1:0]  got, exp, r;
        logic [31:0] d;
        logic [4:0]  a;
        logic [3:0]  s;
        int          c0;

        m_mask = '{32'h0, 32'h0, 32'h0000_003F, 32'h00FF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0};
        tbl[0]  = '{5'h08, 32'h0000_0025, 4'hF, OK,  32'h0000_0025, OK};
        tbl[1]  = '{5'h08, 32'hFFFF_FFFF, 4'h1, OK,  32'h0000_003F, OK};
        tbl[2]  = '{5'h08, 32'h0000_0000, 4'h2, OK,  32'h0000_003F, OK};
        tbl[3]  = '{5'h0C, 32'h00AA_BBCC, 4'h3, OK,  32'h0000_BBCC, OK};
        tbl[4]  = '{5'h0C, 32'hFF11_2233, 4'h4, OK,  32'h0011_BBCC, OK};
        tbl[5]  = '{5'h0C, 32'h1234_5678, 4'h8, OK,  32'h0011_BBCC, OK};
        tbl[6]  = '{5'h10, 32'h1234_5678, 4'hF, OK,  32'h1234_5678, OK};
        tbl[7]  = '{5'h10, 32'hAAAA_AAAA, 4'h2, OK,  32'h1234_AA78, OK};
        tbl[8]  = '{5'h14, 32'hFFFF_FFFF, 4'hF, OK,  32'h0000_0000, OK};
        tbl[9]  = '{5'h04, 32'h0000_0001, 4'hF, OK,  32'h0000_0000, OK};
        tbl[10] = '{5'h00, 32'h0000_0000, 4'hF, OK,  32'h0000_0000, OK};
        tbl[11] = '{5'h18, 32'hFFFF_FFFF, 4'hF, ERR, 32'h0000_0000, ERR};
        tbl[12] = '{5'h1C, 32'h1234_5678, 4'hF, ERR, 32'h0000_0000, ERR};

        // ---------------- clock/reset ----------------
        RST = 1; awaddr = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0; bready = 0;
        araddr = 0; arvalid = 0; rready = 0; busy_i = 0; miso = 0;
        model_reset();
        repeat (3) @(negedge GCLK);
        check("rst_awready", {31'd0, awready}, 32'd0);
        check("rst_wready", {31'd0, wready}, 32'd0);
        check("rst_arready", {31'd0, arready}, 32'd0);
        check("rst_bvalid", {31'd0, bvalid}, 32'd0);
        check("rst_rvalid", {31'd0, rvalid}, 32'd0);
        check("rst_start", {31'd0, start_o}, 32'd0);
        check("rst_cfg_out", {26'd0, word_len, sck_speed, spi_mode}, 32'd0);
        check("rst_timing_out", {8'd0, sck_cs, cs_sck, ifg}, 32'd0);
        check("rst_mosi", mosi, 32'd0);
        RST = 0;

        // ---------------- table vectors ----------------
        for (int i = 0; i < 13; i++) begin
            wr(tbl[i].addr, tbl[i].data, tbl[i].strb, i % 3, (i + 1) % 4, 0, got, exp);
            check($sformatf("tbl%0d_bresp", i), {30'd0, got}, {30'd0, tbl[i].bresp});
            axi_read(tbl[i].addr, d, r);
            check($sformatf("tbl%0d_rdata", i), d, tbl[i].rdata);
            check($sformatf("tbl%0d_rresp", i), {30'd0, r}, {30'd0, tbl[i].rresp});
        end

        // ---------------- CONFIG decode to outputs ----------------
        wr(5'h08, 32'h0000_0025, 4'hF, 0, 0, 0, got, exp);
        check("cfg_bresp", {30'd0, got}, {30'd0, OK});
        check("cfg_mode", {30'd0, spi_mode}, 32'd1);
        check("cfg_speed", {30'd0, sck_speed}, 32'd1);
        check("cfg_wlen", {30'd0, word_len}, 32'd2);
        axi_read(5'h08, d, r);
        check("cfg_readback", d, 32'h25);
        check("cfg_rresp", {30'd0, r}, {30'd0, OK});

        // ---------------- W three cycles ahead of AW ----------------
        wr(5'h10, 32'hA5A5_1234, 4'hF, 3, 0, 0, got, exp);
        check("w_first_bresp", {30'd0, got}, {30'd0, OK});
        check("w_first_single_b", {31'd0, bvalid}, 32'd0);
        repeat (3) @(negedge GCLK);
        check("w_first_no_extra_b", {31'd0, bvalid}, 32'd0);
        check("w_first_mosi", mosi, 32'hA5A5_1234);

        // ---------------- start pulse and pending busy ----------------
        c0 = start_cnt;
        wr(5'h00, 32'h0000_0001, 4'hF, 0, 0, 0, got, exp);
        repeat (3) @(negedge GCLK);
        check("start_bresp", {30'd0, got}, {30'd0, OK});
        check("start_pulse_cycles", start_cnt - c0, 32'd1);
        axi_read(5'h04, d, r);
        check("status_pending", d, 32'h1);

        // ---------------- transfer completion ----------------
        miso = 32'hDEAD_BEEF;
        busy_i = 1;
        repeat (10) @(negedge GCLK);
        busy_i = 0;
        m_rx = 32'hDEAD_BEEF; m_done = 1;
        repeat (2) @(negedge GCLK);
        axi_read(5'h14, d, r);
        check("rx_capture", d, 32'hDEAD_BEEF);
        axi_read(5'h04, d, r);
        check("status_done", d, 32'h2);
        wr(5'h04, 32'h0000_0002, 4'h1, 1, 0, 0, got, exp);
        check("w1c_bresp", {30'd0, got}, {30'd0, OK});
        axi_read(5'h04, d, r);
        check("status_cleared", d, 32'h0);

        // ---------------- writes while busy ----------------
        busy_i = 1;
        c0 = start_cnt;
        @(negedge GCLK);
        wr(5'h00, 32'h0000_0001, 4'hF, 0, 2, 1, got, exp);
        check("busy_start_bresp", {30'd0, got}, {30'd0, ERR});
        wr(5'h10, 32'h0000_0001, 4'hF, 2, 0, 1, got, exp);
        check("busy_tx_bresp", {30'd0, got}, {30'd0, ERR});
        repeat (2) @(negedge GCLK);
        check("busy_no_start", start_cnt - c0, 32'd0);
        check("busy_tx_kept", mosi, 32'hA5A5_1234);
        miso = 32'h0BAD_F00D;
        busy_i = 0;
        m_rx = 32'h0BAD_F00D; m_done = 1;
        repeat (2) @(negedge GCLK);
        rd_check("rx_after_busy", 5'h14);
        rd_check("status_after_busy", 5'h04);

        // ---------------- randomized traffic vs model ----------------
        for (int i = 0; i < 60; i++) begin
            a = 5'($urandom_range(0, 7) * 4);
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                if (a == 5'h00) d[1:0] = 2'b00;
                s = 4'($urandom_range(0, 15));
                wr(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), 0, got, exp);
                check($sformatf("rnd%0d_bresp", i), {30'd0, got}, {30'd0, exp});
                check($sformatf("rnd%0d_mosi", i), mosi, m_reg[4]);
                check($sformatf("rnd%0d_cfg_out", i), {26'd0, word_len, sck_speed, spi_mode}, m_reg[2]);
                check($sformatf("rnd%0d_tim_out", i), {8'd0, sck_cs, cs_sck, ifg}, m_reg[3]);
            end else begin
                rd_check($sformatf("rnd%0d", i), a);
            end
        end

        // ---------------- unmapped read ----------------
        axi_read(5'h18, d, r);
        check("unmapped_rdata", d, 32'h0);
        check("unmapped_rresp", {30'd0, r}, {30'd0, ERR});

        // ---------------- reset with B pending ----------------
        begin
            bit acc = 0;
            @(negedge GCLK);
            awaddr = 5'h08; wdata = 32'h3; wstrb = 4'hF; bready = 0;
            awvalid = 1; wvalid = 1;
            for (int i = 0; i < 20 && !acc; i++) begin
                if (awready && wready) acc = 1;
                @(negedge GCLK);
            end
            awvalid = 0; wvalid = 0;
            if (!acc) check("rst_seq_accept_timeout", 32'd0, 32'd1);
            repeat (2) @(negedge GCLK);
            check("bvalid_pending", {31'd0, bvalid}, 32'd1);
            RST = 1;
            @(negedge GCLK);
            check("rst_mid_bvalid", {31'd0, bvalid}, 32'd0);
            check("rst_mid_awready", {31'd0, awready}, 32'd0);
            check("rst_mid_cfg_out", {26'd0, word_len, sck_speed, spi_mode}, 32'd0);
            check("rst_mid_tim_out", {8'd0, sck_cs, cs_sck, ifg}, 32'd0);
            check("rst_mid_mosi", mosi, 32'd0);
            RST = 0;
            model_reset();
            @(negedge GCLK);
            check("post_rst_no_b", {31'd0, bvalid}, 32'd0);
            for (int i = 1; i < 6; i++) rd_check($sformatf("post_rst_reg%0d", i), 5'(i * 4));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
